// File: rtl/decod_display.sv
// Hex/symbol to 7-segment decoder with a registered output stage.
// The decode is combinational; saida comes only from the register, loaded when en=1.
module decod_display #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] entrada,
  output logic [6:0] saida
);

  // Load-enable semantics: no handshake; when en=1 at a rising edge the
  // register takes the decode of entrada, when en=0 it holds its value.

  logic [6:0] pat_al;   // pattern in active-low form (gfedcba, 0 = lit)
  logic [6:0] pat;      // pattern in the configured polarity
  logic [6:0] saida_q;

  localparam logic [6:0] BLANK_AL = 7'h7F;
  localparam logic [6:0] BLANK    = ACTIVE_LOW ? BLANK_AL : ~BLANK_AL;

  always_comb begin
    pat_al = BLANK_AL;
    unique case (entrada)
      4'd0:  pat_al = 7'h40;
      4'd1:  pat_al = 7'h79;
      4'd2:  pat_al = 7'h24;
      4'd3:  pat_al = 7'h30;
      4'd4:  pat_al = 7'h19;
      4'd5:  pat_al = 7'h12;
      4'd6:  pat_al = 7'h02;
      4'd7:  pat_al = 7'h78;
      4'd8:  pat_al = 7'h00;
      4'd9:  pat_al = 7'h10;
      4'd10: pat_al = 7'h08;
      4'd11: pat_al = 7'h03;
      4'd12: pat_al = 7'h46;
      4'd13: pat_al = 7'h21;
      4'd14: pat_al = 7'h3F;  // only g lit: out-of-range marker
      4'd15: pat_al = 7'h7F;  // blank: no value
      default: pat_al = BLANK_AL;
    endcase
  end

  assign pat = ACTIVE_LOW ? pat_al : ~pat_al;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saida_q <= BLANK;
    end else if (en) begin
      saida_q <= pat;
    end
  end

  assign saida = saida_q;

endmodule

// File: tb/tb_decod_display.sv
// Randomized scoreboard bench for decod_display, covering both output polarities.
module tb_decod_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] entrada;
  logic [6:0] saida_lo;
  logic [6:0] saida_hi;

  int n_checks = 0;
  int n_pass   = 0;

  // expected {active-low saida, active-high saida}
  logic [13:0] exp_q[$];

  logic [6:0] digit_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h3F, 7'h7F};
  logic [6:0] shown_lo;
  logic [6:0] shown_hi;

  decod_display #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .entrada(entrada), .saida(saida_lo)
  );
  decod_display #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .entrada(entrada), .saida(saida_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Reference: the display shows the last code loaded, blank after reset.
  task automatic model_edge(input logic r, input logic e, input logic [3:0] c);
    if (r) begin
      shown_lo = 7'h7F;
      shown_hi = 7'h00;
    end else if (e) begin
      shown_lo = digit_tbl[c];
      shown_hi = ~digit_tbl[c];
    end
  endtask

  task automatic step(input logic e, input logic [3:0] c);
    en = e;
    entrada = c;
    @(posedge clk);
    #1;
    model_edge(rst, e, c);
    exp_q.push_back({shown_lo, shown_hi});
  endtask

  // Move entrada mid-cycle; the register must not follow it.
  task automatic glitch_check;
    @(negedge clk);
    #1;
    entrada = 4'($urandom_range(0, 15));
    #1;
    check("mid_cycle_lo", saida_lo, shown_lo);
    check("mid_cycle_hi", saida_hi, shown_hi);
  endtask

  task automatic async_reset_check;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    shown_lo = 7'h7F;
    shown_hi = 7'h00;
    check("async_rst_lo", saida_lo, 7'h7F);
    check("async_rst_hi", saida_hi, 7'h00);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [13:0] e;
      e = exp_q.pop_front();
      check("saida_lo", saida_lo, e[13:7]);
      check("saida_hi", saida_hi, e[6:0]);
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    entrada = 4'd0;
    shown_lo = 7'h7F;
    shown_hi = 7'h00;
    #1;
    check("reset_lo", saida_lo, 7'h7F);
    check("reset_hi", saida_hi, 7'h00);

    // reset overrides en and entrada
    step(1'b1, 4'd3);
    step(1'b1, 4'd8);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 4'd0);

    for (int i = 0; i < 16; i++) step(1'b1, 4'(i));

    step(1'b1, 4'd8);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd1);
    step(1'b1, 4'd1);

    step(1'b1, 4'd5);
    async_reset_check();
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    check("rst_held_lo", saida_lo, 7'h7F);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 4'd9);

    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) glitch_check();
      if ($urandom_range(0, 39) == 0) begin
        async_reset_check();
        step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        @(negedge clk);
        #1;
        rst = 1'b0;
      end
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
